// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: packs accepted bytes into 32-bit words,
// writes them at consecutive word addresses and holds the CPU in reset while loading.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   word_count_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_wr_en_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            checksum_o
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;
    logic [31:0]           word_q,     word_d;
    logic [7:0]            checksum_q, checksum_d;
    logic                  done_q,     done_d;
    logic                  ready_q,    ready_d;
    logic                  wr_en_q,    wr_en_d;
    logic                  busy_q,     busy_d;
    logic [31:0]           addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;

    logic                  start_ok;
    logic                  accept;
    logic [1:0]            lane;
    logic [31:0]           word_ins;
    logic [ADDR_WIDTH:0]   wc_clamped;
    logic [ADDR_WIDTH:0]   word_idx_inc;

    always_comb begin
        start_ok     = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        accept       = byte_valid_i && ready_q;
        lane         = BIG_ENDIAN ? (2'd3 - byte_cnt_q) : byte_cnt_q;
        word_ins     = word_q;
        word_ins[{lane, 3'b000} +: 8] = byte_in_i;
        wc_clamped   = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
        word_idx_inc = word_idx_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        word_d     = word_q;
        checksum_d = checksum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    count_d    = wc_clamped;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    checksum_d = '0;
                    word_d     = '0;
                    state_d    = (wc_clamped == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    word_d     = word_ins;
                    checksum_d = checksum_q ^ byte_in_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = {{(30-ADDR_WIDTH){1'b0}}, word_idx_q[ADDR_WIDTH-1:0], 2'b00};
                        wdata_d = word_ins;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == count_q) ? S_DONE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase

        // Done lags DONE entry by one cycle so a zero-word session still shows a clean 0->1 edge.
        done_d = done_q;
        if (start_ok) begin
            done_d = 1'b0;
        end else if (state_q == S_DONE) begin
            done_d = 1'b1;
        end

        ready_d = (state_d == S_COLLECT);
        wr_en_d = (state_d == S_WRITE);
        busy_d  = (state_d == S_COLLECT) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            word_q     <= word_d;
            checksum_q <= checksum_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign byte_ready_o  = ready_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_addr_o    = addr_q;
    assign mem_wr_data_o = wdata_q;
    assign cpu_hold_o    = busy_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign checksum_o    = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: big- and little-endian instances share one byte stream and
// are compared against a word-packing model built from the session's byte list.
module tb_imem_loader;

    localparam int AW   = 4;
    localparam int MAXW = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [AW:0]   wc;
    logic [7:0]    byte_dat;
    logic          byte_vld;

    logic          be_rdy, be_wen, be_hold, be_busy, be_done;
    logic [31:0]   be_addr, be_wdat;
    logic [7:0]    be_csum;
    logic          le_rdy, le_wen, le_hold, le_busy, le_done;
    logic [31:0]   le_addr, le_wdat;
    logic [7:0]    le_csum;

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .word_count_i(wc),
        .byte_in_i(byte_dat), .byte_valid_i(byte_vld), .byte_ready_o(be_rdy),
        .mem_wr_en_o(be_wen), .mem_addr_o(be_addr), .mem_wr_data_o(be_wdat),
        .cpu_hold_o(be_hold), .busy_o(be_busy), .done_o(be_done), .checksum_o(be_csum)
    );

    imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .word_count_i(wc),
        .byte_in_i(byte_dat), .byte_valid_i(byte_vld), .byte_ready_o(le_rdy),
        .mem_wr_en_o(le_wen), .mem_addr_o(le_addr), .mem_wr_data_o(le_wdat),
        .cpu_hold_o(le_hold), .busy_o(le_busy), .done_o(le_done), .checksum_o(le_csum)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] be_addr_log[$], be_dat_log[$], le_addr_log[$], le_dat_log[$];

    always @(posedge clk) begin
        #1;
        if (be_wen === 1'b1) begin
            be_addr_log.push_back(be_addr);
            be_dat_log.push_back(be_wdat);
        end
        if (le_wen === 1'b1) begin
            le_addr_log.push_back(le_addr);
            le_dat_log.push_back(le_wdat);
        end
    end

    function automatic logic [31:0] model_word(input logic [7:0] b[$], input int i, input bit big);
        if (big) return {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
        return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
    endfunction

    logic [7:0] last_csum;

    task automatic clear_logs();
        be_addr_log.delete(); be_dat_log.delete();
        le_addr_log.delete(); le_dat_log.delete();
    endtask

    // mode 0: continuous, 1: every other cycle with a 10-cycle gap, 2: random gaps
    task automatic run_session(input int wcount, input logic [7:0] bytes[$],
                               input int mode, input bit mid_start);
        int         eff;
        int         idx;
        int         k;
        bit         v;
        bit         hold_ok;
        logic [7:0] csum;

        eff     = (wcount > MAXW) ? MAXW : wcount;
        hold_ok = 1'b1;
        csum    = 8'h00;
        for (int i = 0; i < eff * 4; i++) csum ^= bytes[i];
        clear_logs();

        @(negedge clk);
        start = 1'b1;
        wc    = wcount[AW:0];
        @(negedge clk);
        start = 1'b0;
        check("done_cleared_by_start", {30'd0, be_done, le_done}, 32'd0);

        if (eff == 0) begin
            check("wc0_no_hold", {28'd0, be_hold, le_hold, be_busy, le_busy}, 32'd0);
            @(negedge clk);
            check("wc0_done", {30'd0, be_done, le_done}, 32'h3);
            check("wc0_no_hold_late", {30'd0, be_hold, le_hold}, 32'd0);
            check("wc0_no_writes", be_addr_log.size() + le_addr_log.size(), 32'd0);
            last_csum = 8'h00;
            return;
        end

        check("csum_cleared", {16'd0, be_csum, le_csum}, 32'd0);

        idx = 0;
        k   = 0;
        while (idx < eff * 4 && k < 3000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0) && !(k >= 6 && k < 16);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            byte_vld = v;
            byte_dat = v ? bytes[idx] : 8'($urandom);
            if (mid_start && k == 3) begin
                start = 1'b1;
                wc    = 1;
            end else begin
                start = 1'b0;
            end
            if (!(be_hold && le_hold && be_busy && le_busy)) hold_ok = 1'b0;
            if (be_rdy !== le_rdy) hold_ok = 1'b0;
            if (v && be_rdy) idx++;
            k++;
            @(negedge clk);
        end
        byte_vld = 1'b0;
        start    = 1'b0;
        if (k >= 3000) check("byte_accept_timeout", idx, eff * 4);

        check("final_write_strobe", {30'd0, be_wen, le_wen}, 32'h3);
        if (!(be_hold && le_hold && be_busy && le_busy)) hold_ok = 1'b0;
        check("hold_through_write", {31'd0, hold_ok}, 32'd1);

        @(negedge clk);
        check("release_after_write", {26'd0, be_hold, le_hold, be_busy, le_busy, be_wen, le_wen}, 32'd0);
        @(negedge clk);
        check("done_set", {30'd0, be_done, le_done}, 32'h3);

        check("be_write_count", be_addr_log.size(), eff);
        check("le_write_count", le_addr_log.size(), eff);
        for (int i = 0; i < eff && i < be_addr_log.size() && i < le_addr_log.size(); i++) begin
            check($sformatf("be_addr[%0d]", i), be_addr_log[i], 32'(i * 4));
            check($sformatf("be_data[%0d]", i), be_dat_log[i], model_word(bytes, i, 1'b1));
            check($sformatf("le_addr[%0d]", i), le_addr_log[i], 32'(i * 4));
            check($sformatf("le_data[%0d]", i), le_dat_log[i], model_word(bytes, i, 1'b0));
        end
        check("checksum", {16'd0, be_csum, le_csum}, {16'd0, csum, csum});
        check("be_addr_hold", be_addr, 32'((eff - 1) * 4));
        check("be_data_hold", be_wdat, model_word(bytes, eff - 1, 1'b1));
        check("le_data_hold", le_wdat, model_word(bytes, eff - 1, 1'b0));
        last_csum = csum;
    endtask

    task automatic offer_in_done();
        bit rdy_seen;
        int nw;
        rdy_seen = 1'b0;
        nw       = be_addr_log.size();
        for (int i = 0; i < 6; i++) begin
            byte_vld = 1'b1;
            byte_dat = 8'($urandom);
            if (be_rdy || le_rdy) rdy_seen = 1'b1;
            @(negedge clk);
        end
        byte_vld = 1'b0;
        check("done_not_ready", {31'd0, rdy_seen}, 32'd0);
        check("done_csum_stable", {16'd0, be_csum, le_csum}, {16'd0, last_csum, last_csum});
        check("done_no_write", be_addr_log.size(), nw);
        check("done_still_set", {30'd0, be_done, le_done}, 32'h3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] q[$];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        wc       = '0;
        byte_dat = 8'h00;
        byte_vld = 1'b0;
        last_csum = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {22'd0, be_rdy, be_wen, be_hold, be_busy, be_done,
                             le_rdy, le_wen, le_hold, le_busy, le_done}, 32'd0);
        check("reset_addr_data", be_addr | be_wdat | le_addr | le_wdat, 32'd0);
        check("reset_csum", {16'd0, be_csum, le_csum}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a word must abandon the session immediately.
        @(negedge clk);
        start = 1'b1;
        wc    = 1;
        @(negedge clk);
        start    = 1'b0;
        byte_vld = 1'b1;
        byte_dat = 8'hAA;
        @(negedge clk);
        byte_dat = 8'hBB;
        @(negedge clk);
        byte_vld = 1'b0;
        check("pre_reset_csum", {24'd0, be_csum}, 32'h0000_0011);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {22'd0, be_rdy, be_wen, be_hold, be_busy, be_done,
                                   le_rdy, le_wen, le_hold, le_busy, le_done}, 32'd0);
        check("async_reset_csum", {16'd0, be_csum, le_csum}, 32'd0);
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_write_after_reset", be_addr_log.size() + le_addr_log.size(), 32'd0);

        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(1, q, 0, 1'b0);

        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session(2, q, 0, 1'b0);
        check("mips_checksum", {24'd0, be_csum}, 32'h0000_002D);

        q = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_session(1, q, 0, 1'b0);
        check("le_word", le_wdat, 32'h1122_3344);

        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session(2, q, 1, 1'b0);

        q.delete();
        run_session(0, q, 0, 1'b0);

        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_session(3, q, 1, 1'b1);
        offer_in_done();
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_session(1, q, 0, 1'b0);

        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(1, 5);
            q.delete();
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            run_session(n, q, 2, 1'b0);
        end

        q.delete();
        for (int i = 0; i < 4 * MAXW; i++) q.push_back(8'($urandom));
        run_session(20, q, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch unit reads.
- Accepts a byte stream over a valid/ready handshake (from a UART receiver or debug port) and assembles bytes into 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the fetch unit in reset while loading, then releases it so execution starts at address 0.

Parameters:
- ADDR_WIDTH, 8, word-index width; maximum image is 2^ADDR_WIDTH words.
- BIG_ENDIAN, 1, 1 = first received byte goes to [31:24] (MIPS order); 0 = first byte goes to [7:0].

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a load session.
- WordCount  input  ADDR_WIDTH+1  number of words to load; sampled on the accepted Start.
- ByteIn  input  8  incoming data byte.
- ByteValid  input  1  ByteIn is valid.
- ByteReady  output  1  loader can accept a byte this cycle.
- MemWrEn  output  1  instruction memory write strobe.
- MemAddr  output  32  byte address, word-aligned: {word_idx, 2'b00}, zero-extended.
- MemWrData  output  32  assembled instruction word.
- CpuHold  output  1  high holds the PC/fetch unit in reset.
- Busy  output  1  session in progress.
- Done  output  1  sticky completion flag; cleared by the next accepted Start.
- Checksum  output  8  XOR of all bytes accepted in the current session.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE.
  - All outputs are 0: ByteReady, MemWrEn, MemAddr, MemWrData, CpuHold, Busy, Done, Checksum.
  - Internal byte counter and word index are cleared.
  - Reset mid-session abandons the session; no further writes occur.
- All outputs are registered.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE, on Start=1:
  - Latch WordCount; clear word_idx, byte_cnt and Checksum; clear Done.
  - If WordCount==0, go to DONE and set Done=1 on the next cycle; CpuHold is never raised.
  - Otherwise go to COLLECT.
- COLLECT:
  - ByteReady=1, Busy=1, CpuHold=1.
  - A byte is accepted when ByteValid && ByteReady.
  - Each accepted byte is placed in its lane according to BIG_ENDIAN and byte_cnt, and XORed into Checksum.
  - byte_cnt increments, wrapping 3 -> 0.
  - On the 4th accepted byte, go to WRITE.
  - ByteValid while ByteReady=0 is not accepted; the source must hold the byte.
- WRITE (exactly one cycle):
  - MemWrEn=1; MemAddr=word_idx*4; MemWrData=assembled word.
  - ByteReady=0; Busy=1; CpuHold=1.
  - The 4th byte accepted at edge N produces MemWrEn high during cycle N+1.
  - After the write, word_idx increments.
  - If the incremented word_idx == latched WordCount, go to DONE; else go to COLLECT.
- DONE:
  - Done=1, Busy=0, CpuHold=0 (deasserts in the cycle after the final write).
  - MemWrEn=0; MemAddr and MemWrData hold the last values.
- Start is ignored while Busy=1.
- Bytes offered in IDLE or DONE are not accepted (ByteReady=0).
- A partial word at session end never happens: a session ends only after WordCount full words.
- WordCount > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH. word_idx never wraps within a session.
- Start and ByteValid in the same cycle while in IDLE: Start is taken; the byte is not accepted (ByteReady was 0).
- Throughput: with ByteValid held high, one word every 5 cycles (4 COLLECT + 1 WRITE).

Test Plan:
- Reset low mid-COLLECT after 2 bytes -> all outputs 0 immediately (asynchronous); after release, Start with WordCount=1 and bytes 0x11,0x22,0x33,0x44 -> single write Addr=0x0, Data=0x11223344.
- WordCount=2, BIG_ENDIAN=1, continuous bytes 20 08 00 05 / 00 00 00 00 -> writes (0x0,0x20080005) and (0x4,0x00000000); CpuHold high from the cycle after Start through the final WRITE; Done=1; Checksum=0x2D.
- BIG_ENDIAN=0, bytes 0x44,0x33,0x22,0x11 -> Data=0x11223344.
- ByteValid toggled every other cycle plus one 10-cycle gap -> same writes as the continuous case; no byte lost or duplicated; MemWrEn exactly one cycle per word.
- WordCount=0 -> Done=1 two cycles after Start; no MemWrEn; CpuHold stays 0.
- Start pulsed again mid-session and bytes offered in DONE -> Start ignored and bytes not accepted; a Start after DONE clears Done, Checksum=0, and the next write goes to Addr=0x0.
